capture_buffer: RTL and testbench
=================================

CAPTURE_BUFFER -- requirements
Module: capture_buffer

Interface
REQ-001 Parameter LENGTH, default 16, is the number of buffer entries; legal values are 2 or more.
REQ-002 Parameter DATA_W, default 8, is the sample width in bits.
REQ-003 Derived constant AW = $clog2(LENGTH)+1 is the address/count width, matching the address-counter width used across the codebase.
REQ-004 clk  in  1  single clock; all state changes on the rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  arms a new capture; sampled only in IDLE or FULL.
REQ-007 in_valid  in  1  producer has a sample on in_data.
REQ-008 in_data  in  DATA_W  sample to store.
REQ-009 in_ready  out  1  buffer accepts a sample this cycle.
REQ-010 rd_addr  in  AW  read address from the downstream reader.
REQ-011 rd_data  out  DATA_W  registered read data.
REQ-012 wr_count  out  AW  number of samples stored in the current capture.
REQ-013 busy  out  1  high while in CAPTURE.
REQ-014 done  out  1  high while in FULL (level, not pulse).

Function
REQ-015 FSM states SHALL be IDLE, CAPTURE and FULL.
REQ-016 IDLE: start=1 -> CAPTURE with wr_count cleared to 0; otherwise stay.
REQ-017 CAPTURE: in_ready=1, busy=1; a transfer occurs only when in_valid and in_ready are both 1 on the same rising edge.
REQ-018 On a transfer, mem[wr_count] <= in_data and wr_count <= wr_count+1 (AW-bit, no wrap).
REQ-019 A transfer with wr_count == LENGTH-1 SHALL be the final one; the next state is FULL and wr_count reads LENGTH.
REQ-020 start in CAPTURE SHALL be ignored; the capture is not restarted.
REQ-021 in_valid=0 in CAPTURE SHALL hold state and wr_count; no timeout.
REQ-022 FULL: in_ready=0, done=1, wr_count holds LENGTH; in_valid is ignored and memory is not written.
REQ-023 FULL with start=1 -> CAPTURE with wr_count cleared; previous contents remain readable until overwritten.
REQ-024 in_ready, busy and done SHALL be decoded combinationally from the state only, with no dependence on in_valid.
REQ-025 Read: rd_data <= mem[rd_addr] every cycle in every state; latency is 1 clock.
REQ-026 rd_addr >= LENGTH SHALL return rd_data = 0.
REQ-027 A read and a write to the same address in the same cycle SHALL return the old data.
REQ-028 Entries never written since reset SHALL read undefined; the bench must not check them.

Reset
REQ-029 rst=0 forces state IDLE, wr_count=0 and rd_data=0 immediately, independent of clk.
REQ-030 Outputs during and after reset: in_ready=0, busy=0, done=0.
REQ-031 Memory contents are not reset.
REQ-032 Reset asserted mid-capture abandons the capture; a new start is required after release.

Structure
REQ-033 The state encoding (IDLE/CAPTURE/FULL enum) and the AW width function belong in the shared project package.
REQ-034 Storage SHALL be one sub-module, capture_ram: single write port, single registered read port, inferable as block RAM.
REQ-035 FSM, write counter and read-range check reside in capture_buffer.

Verification
REQ-036 Reset then start with in_valid held high and in_data = 0x10..0x1F (LENGTH=16) -> done rises 16 cycles after CAPTURE entry; reads of addresses 0..15 return 0x10..0x1F one cycle after each address.
REQ-037 In CAPTURE, toggle in_valid 1,0,1,0 -> only 2 writes; wr_count = 2; in_ready stays 1.
REQ-038 In FULL, in_valid=1 with in_data=0xAA -> no write, in_ready=0; a re-read of address 0 still returns 0x10.
REQ-039 After 5 transfers, assert start -> ignored, wr_count=5; then drop rst for 1 cycle -> state IDLE, wr_count=0, rd_data=0, done=0.
REQ-040 rd_addr=16 (LENGTH=16) -> rd_data=0; a same-cycle write to and read of address 3 -> old value returned, new value on the next read.
REQ-041 From FULL, start -> CAPTURE, wr_count=0; one write of 0x55 -> address 0 reads 0x55 and address 1 still reads 0x11.

Source files
------------

// File: rtl/capture_buffer_pkg.sv
// capture_buffer_pkg: shared FSM state encoding and address-width helper
package capture_buffer_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        FULL    = 2'd2
    } state_t;

    // One extra bit over the index width so a count can hold LENGTH itself.
    function automatic int aw_of(input int length);
        return $clog2(length) + 1;
    endfunction

endpackage

// File: rtl/capture_ram.sv
// capture_ram: single write port, single registered read port storage
//   clk     in  clock
//   we      in  write enable
//   wa      in  write address
//   wd      in  write data
//   ra      in  read address
//   rd_data out read data, one clock after ra
module capture_ram #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 8,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] wa,
    input  logic [DATA_W-1:0] wd,
    input  logic [ADDR_W-1:0] ra,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_data_q;

    // Read samples the array before this edge's write lands: old data wins.
    always_ff @(posedge clk) begin
        if (we) mem[wa] <= wd;
        rd_data_q <= mem[ra];
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/capture_buffer.sv
// capture_buffer: one-shot sample capture into a LENGTH-entry buffer
//   clk      in  clock
//   rst      in  asynchronous active-low reset
//   start    in  arm a new capture (IDLE or FULL only)
//   in_valid in  producer sample valid
//   in_data  in  producer sample
//   in_ready out buffer accepts a sample (CAPTURE)
//   rd_addr  in  read address
//   rd_data  out registered read data, 0 for out-of-range addresses
//   wr_count out samples stored in the current capture
//   busy     out high in CAPTURE
//   done     out high in FULL
module capture_buffer
    import capture_buffer_pkg::*;
#(
    parameter int LENGTH = 16,
    parameter int DATA_W = 8,
    localparam int AW    = aw_of(LENGTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic [AW-1:0]     wr_count,
    output logic              busy,
    output logic              done
);

    state_t            state_q, state_d;
    logic [AW-1:0]     wr_count_q, wr_count_d;
    logic              in_range_q, in_range_d;
    logic              we;
    logic [DATA_W-1:0] ram_rd;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            wr_count_q <= '0;
            in_range_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_count_q <= wr_count_d;
            in_range_q <= in_range_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wr_count_d = wr_count_q;
        unique case (state_q)
            IDLE, FULL: begin
                if (start) begin
                    state_d    = CAPTURE;
                    wr_count_d = '0;
                end
            end
            CAPTURE: begin
                if (in_valid) begin
                    wr_count_d = wr_count_q + 1'b1;
                    if (wr_count_q == AW'(LENGTH - 1)) state_d = FULL;
                end
            end
            default: begin
                state_d    = IDLE;
                wr_count_d = '0;
            end
        endcase
    end

    assign in_ready   = (state_q == CAPTURE);
    assign busy       = (state_q == CAPTURE);
    assign done       = (state_q == FULL);
    assign wr_count   = wr_count_q;
    assign we         = in_ready && in_valid;
    assign in_range_d = (rd_addr < AW'(LENGTH));

    capture_ram #(
        .DEPTH (LENGTH),
        .DATA_W(DATA_W),
        .ADDR_W(AW - 1)
    ) u_ram (
        .clk    (clk),
        .we     (we),
        .wa     (wr_count_q[AW-2:0]),
        .wd     (in_data),
        .ra     (rd_addr[AW-2:0]),
        .rd_data(ram_rd)
    );

    // The range flag travels with the read so the mask lines up with its data;
    // clearing it in reset also forces rd_data to 0 without touching the RAM.
    assign rd_data = in_range_q ? ram_rd : '0;

endmodule

// File: tb/tb_capture_buffer.sv
// tb_capture_buffer: scoreboard bench for capture_buffer (LENGTH=16, DATA_W=8)
module tb_capture_buffer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = '0;
    logic       in_ready;
    logic [4:0] rd_addr = '0;
    logic [7:0] rd_data;
    logic [4:0] wr_count;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q [$];

    always #5 clk = ~clk;

    capture_buffer #(.LENGTH(16), .DATA_W(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .in_valid(in_valid),
        .in_data (in_data),
        .in_ready(in_ready),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .wr_count(wr_count),
        .busy    (busy),
        .done    (done)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic read_chk(input string tag, input logic [4:0] a, input logic [7:0] e);
        rd_addr = a;
        exp_q.push_back(e);
        tick();
        chk(tag, rd_data, exp_q.pop_front());
    endtask

    task automatic flags_chk(input string tag, input logic r, input logic b, input logic d);
        chk({tag, "_in_ready"}, in_ready, r);
        chk({tag, "_busy"}, busy, b);
        chk({tag, "_done"}, done, d);
    endtask

    initial begin
        #3;
        flags_chk("reset", 1'b0, 1'b0, 1'b0);
        chk("reset_wr_count", wr_count, 0);
        chk("reset_rd_data", rd_data, 0);
        tick();
        rst = 1'b1;
        tick();
        flags_chk("idle", 1'b0, 1'b0, 1'b0);

        start = 1'b1;
        tick();
        start = 1'b0;
        flags_chk("cap_entry", 1'b1, 1'b1, 1'b0);
        chk("cap_entry_wr_count", wr_count, 0);
        in_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            in_data = 8'h10 + 8'(i);
            tick();
            chk($sformatf("fill_done_%0d", i), done, i == 15);
            chk($sformatf("fill_wr_count_%0d", i), wr_count, i + 1);
        end
        in_valid = 1'b0;
        for (int i = 0; i < 16; i++)
            read_chk($sformatf("fill_rd_%0d", i), 5'(i), 8'h10 + 8'(i));

        in_valid = 1'b1;
        in_data  = 8'hAA;
        tick();
        flags_chk("full_ignore", 1'b0, 1'b0, 1'b1);
        chk("full_wr_count", wr_count, 16);
        in_valid = 1'b0;
        read_chk("full_rd0", 5'd0, 8'h10);
        read_chk("oob_rd16", 5'd16, 8'h00);
        read_chk("oob_rd31", 5'd31, 8'h00);

        start = 1'b1;
        tick();
        start = 1'b0;
        flags_chk("restart", 1'b1, 1'b1, 1'b0);
        chk("restart_wr_count", wr_count, 0);
        in_valid = 1'b1;
        in_data  = 8'h55;
        tick();
        in_valid = 1'b0;
        read_chk("rewrite_rd0", 5'd0, 8'h55);
        read_chk("rewrite_rd1", 5'd1, 8'h11);

        for (int i = 0; i < 4; i++) begin
            in_valid = (i % 2 == 0);
            in_data  = in_valid ? 8'h60 + 8'(i) : 8'hEE;
            tick();
            chk($sformatf("toggle_in_ready_%0d", i), in_ready, 1);
        end
        in_valid = 1'b0;
        chk("toggle_wr_count", wr_count, 3);
        read_chk("toggle_rd1", 5'd1, 8'h60);
        read_chk("toggle_rd2", 5'd2, 8'h62);

        in_valid = 1'b1;
        in_data  = 8'h77;
        read_chk("rw_same_old", 5'd3, 8'h13);
        in_valid = 1'b0;
        read_chk("rw_same_new", 5'd3, 8'h77);

        in_valid = 1'b1;
        in_data  = 8'h88;
        tick();
        in_valid = 1'b0;
        chk("five_wr_count", wr_count, 5);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_ignored_wr_count", wr_count, 5);
        chk("start_ignored_busy", busy, 1);

        rd_addr = 5'd4;
        tick();
        chk("pre_reset_rd4", rd_data, 8'h88);
        rst = 1'b0;
        #1;
        flags_chk("async_reset", 1'b0, 1'b0, 1'b0);
        chk("async_reset_wr_count", wr_count, 0);
        chk("async_reset_rd_data", rd_data, 0);
        tick();
        rst = 1'b1;
        tick();
        tick();
        flags_chk("post_reset", 1'b0, 1'b0, 1'b0);
        read_chk("mem_kept_rd0", 5'd0, 8'h55);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
